// File: rtl/nios_system_dpram_arb.sv
// True-dual-port Avalon-MM RAM with write-collision arbitration, fairness and reset_req freeze.
// Define NIOS_DPRAM_OUTREG_EN to add an output register per port (read latency 2 instead of 1).
module nios_system_dpram_arb #(
  parameter int    DATA_WIDTH = 32,
  parameter int    BE_WIDTH   = DATA_WIDTH / 8,
  parameter int    ADDR_WIDTH = 9,
  parameter int    DEPTH      = 512,
  parameter string INIT_FILE  = "nios_system_RAM_block.hex"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reset_req,
  input  logic [ADDR_WIDTH-1:0] s1_address,
  input  logic [BE_WIDTH-1:0]   s1_byteenable,
  input  logic                  s1_chipselect,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [DATA_WIDTH-1:0] s1_writedata,
  output logic [DATA_WIDTH-1:0] s1_readdata,
  output logic                  s1_readdatavalid,
  output logic                  s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0] s2_address,
  input  logic [BE_WIDTH-1:0]   s2_byteenable,
  input  logic                  s2_chipselect,
  input  logic                  s2_read,
  input  logic                  s2_write,
  input  logic [DATA_WIDTH-1:0] s2_writedata,
  output logic [DATA_WIDTH-1:0] s2_readdata,
  output logic                  s2_readdatavalid,
  output logic                  s2_waitrequest
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {PRI_S1, PRI_S2} arb_t;
  arb_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] addr  [2];
  logic [BE_WIDTH-1:0]   be    [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic [1:0] wr, rd, hit, lost, stall, wr_acc, rd_acc;
  logic       collision;

  assign addr[0]  = s1_address;
  assign addr[1]  = s2_address;
  assign be[0]    = s1_byteenable;
  assign be[1]    = s2_byteenable;
  assign wdata[0] = s1_writedata;
  assign wdata[1] = s2_writedata;

  // A command carrying both read and write is treated purely as a write.
  assign wr  = {s2_chipselect & s2_write, s1_chipselect & s1_write};
  assign rd  = {s2_chipselect & s2_read & ~s2_write, s1_chipselect & s1_read & ~s1_write};
  assign hit = {({1'b0, addr[1]} < DEPTH_L), ({1'b0, addr[0]} < DEPTH_L)};

  assign collision = wr[0] & wr[1] & (addr[0] == addr[1]);
  assign lost      = {collision & (state == PRI_S1), collision & (state == PRI_S2)};
  assign stall     = ({2{reset_req}} | lost) & {2{~reset}};
  assign wr_acc    = wr & ~stall & {2{~reset}};
  assign rd_acc    = rd & ~stall & {2{~reset}};

  assign s1_waitrequest = stall[0];
  assign s2_waitrequest = stall[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= PRI_S1;
    else       state <= state_nxt;
  end

  // Priority flips to s2 after it loses a collision and returns once s2 has written.
  always_comb begin
    state_nxt = state;
    if (!reset_req) begin
      unique case (state)
        PRI_S1: if (collision) state_nxt = PRI_S2;
        PRI_S2: if (wr_acc[1]) state_nxt = PRI_S1;
        default: state_nxt = PRI_S1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (wr_acc[p] && hit[p]) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (be[p][b]) mem[addr[p][IDX_W-1:0]][b*8 +: 8] <= wdata[p][b*8 +: 8];
        end
      end
    end
  end

  // Stage p0: RAM read register; sees pre-write contents on a same-cycle write.
  logic [DATA_WIDTH-1:0] rdata_p0 [2];
  logic [1:0]            vld_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0      <= '0;
      rdata_p0[0] <= '0;
      rdata_p0[1] <= '0;
    end else begin
      vld_p0 <= rd_acc;
      for (int p = 0; p < 2; p++) begin
        if (rd_acc[p]) rdata_p0[p] <= hit[p] ? mem[addr[p][IDX_W-1:0]] : '0;
      end
    end
  end

`ifdef NIOS_DPRAM_OUTREG_EN
  // Stage p1: output register.
  logic [DATA_WIDTH-1:0] rdata_p1 [2];
  logic [1:0]            vld_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1      <= '0;
      rdata_p1[0] <= '0;
      rdata_p1[1] <= '0;
    end else begin
      vld_p1 <= vld_p0;
      for (int p = 0; p < 2; p++) begin
        if (vld_p0[p]) rdata_p1[p] <= rdata_p0[p];
      end
    end
  end

  assign s1_readdata      = rdata_p1[0];
  assign s2_readdata      = rdata_p1[1];
  assign s1_readdatavalid = vld_p1[0];
  assign s2_readdatavalid = vld_p1[1];
`else
  assign s1_readdata      = rdata_p0[0];
  assign s2_readdata      = rdata_p0[1];
  assign s1_readdatavalid = vld_p0[0];
  assign s2_readdatavalid = vld_p0[1];
`endif

endmodule

// File: tb/tb_nios_system_dpram_arb.sv
// Bench for nios_system_dpram_arb: directed vector table, randomized traffic against a reference model,
// and reset corner cases. Honors NIOS_DPRAM_OUTREG_EN for read latency.
module tb_nios_system_dpram_arb;
  localparam int AW    = 9;
  localparam int DEPTH = 300;
`ifdef NIOS_DPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic cs, rd, wr;
    logic [AW-1:0] addr;
    logic [3:0] be;
    logic [31:0] wd;
  } cmd_t;

  typedef struct packed {
    cmd_t c1, c2;
    logic rr, ew1, ew2;
    logic [31:0] er1, er2;
  } vec_t;

  typedef struct packed {
    int due;
    logic [31:0] d;
  } resp_t;

  logic clk = 1'b0;
  logic reset, reset_req;
  logic [AW-1:0] s1_address, s2_address;
  logic [3:0] s1_byteenable, s2_byteenable;
  logic s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [31:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
  logic s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest;

  always #5 clk = ~clk;

  nios_system_dpram_arb #(
    .DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [31:0] mem_m [DEPTH];
  bit turn2;
  resp_t q1[$], q2[$];
  logic last_w1, last_w2;
  vec_t tab[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic cmd_t idle_c();
    cmd_t c = '0;
    return c;
  endfunction

  function automatic cmd_t wr_c(input int a, input logic [31:0] d, input logic [3:0] be);
    cmd_t c = '0;
    c.cs = 1'b1; c.wr = 1'b1; c.addr = AW'(a); c.be = be; c.wd = d;
    return c;
  endfunction

  function automatic cmd_t rd_c(input int a);
    cmd_t c = '0;
    c.cs = 1'b1; c.rd = 1'b1; c.addr = AW'(a);
    return c;
  endfunction

  function automatic vec_t mk(input cmd_t c1, input cmd_t c2, input logic rr, input logic ew1,
                              input logic ew2, input logic [31:0] er1, input logic [31:0] er2);
    vec_t v;
    v.c1 = c1; v.c2 = c2; v.rr = rr; v.ew1 = ew1; v.ew2 = ew2; v.er1 = er1; v.er2 = er2;
    return v;
  endfunction

  function automatic cmd_t rand_c();
    cmd_t c = '0;
    int pool [8];
    int k;
    pool = '{0, 1, 2, 3, 298, 299, 300, 400};
    c.cs   = ($urandom_range(0, 5) != 0);
    k      = $urandom_range(0, 9);
    c.rd   = (k <= 3) || (k == 8);
    c.wr   = (k >= 4) && (k <= 8);
    c.addr = AW'(pool[$urandom_range(0, 7)]);
    c.be   = 4'($urandom_range(0, 15));
    c.wd   = $urandom;
    return c;
  endfunction

  function automatic logic [31:0] expw(input int a);
    case (a)
      3:       return 32'h0000_0011;
      5:       return 32'hDEAD_BEEF;
      7:       return 32'h11BB_33DD;
      9:       return 32'h0000_CAFE;
      10:      return 32'h55AA_55AA;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [AW-1:0] a);
    if (int'(a) < DEPTH) return mem_m[int'(a)];
    return 32'h0;
  endfunction

  task automatic m_write(input cmd_t c);
    if (int'(c.addr) < DEPTH)
      for (int b = 0; b < 4; b++)
        if (c.be[b]) mem_m[int'(c.addr)][8*b +: 8] = c.wd[8*b +: 8];
  endtask

  task automatic drive(input cmd_t c1, input cmd_t c2, input logic rr);
    s1_chipselect = c1.cs; s1_read = c1.rd; s1_write = c1.wr;
    s1_address = c1.addr; s1_byteenable = c1.be; s1_writedata = c1.wd;
    s2_chipselect = c2.cs; s2_read = c2.rd; s2_write = c2.wr;
    s2_address = c2.addr; s2_byteenable = c2.be; s2_writedata = c2.wd;
    reset_req = rr;
  endtask

  task automatic chk_resp();
    if (q1.size() > 0 && q1[0].due == cyc) begin
      chk("s1_readdatavalid", 32'(s1_readdatavalid), 32'd1);
      chk("s1_readdata", s1_readdata, q1[0].d);
      void'(q1.pop_front());
    end else chk("s1_readdatavalid", 32'(s1_readdatavalid), 32'd0);
    if (q2.size() > 0 && q2[0].due == cyc) begin
      chk("s2_readdatavalid", 32'(s2_readdatavalid), 32'd1);
      chk("s2_readdata", s2_readdata, q2[0].d);
      void'(q2.pop_front());
    end else chk("s2_readdatavalid", 32'(s2_readdatavalid), 32'd0);
  endtask

  // One bus cycle: drive, check at negedge, advance the reference model, step past posedge.
  task automatic run_cycle(input cmd_t c1, input cmd_t c2, input logic rr, input logic tabm,
                           input logic ew1, input logic ew2, input logic [31:0] er1, input logic [31:0] er2);
    logic coll, mw1, mw2, a1, a2;
    resp_t r;
    drive(c1, c2, rr);
    @(negedge clk);
    coll = c1.cs & c1.wr & c2.cs & c2.wr & (c1.addr == c2.addr);
    mw1  = rr | (coll & turn2);
    mw2  = rr | (coll & ~turn2);
    chk("s1_waitrequest", 32'(s1_waitrequest), 32'(tabm ? ew1 : mw1));
    chk("s2_waitrequest", 32'(s2_waitrequest), 32'(tabm ? ew2 : mw2));
    chk_resp();
    a1 = c1.cs & (c1.rd | c1.wr) & ~mw1;
    a2 = c2.cs & (c2.rd | c2.wr) & ~mw2;
    if (a1 & c1.rd & ~c1.wr) begin
      r.due = cyc + LAT; r.d = tabm ? er1 : m_read(c1.addr); q1.push_back(r);
    end
    if (a2 & c2.rd & ~c2.wr) begin
      r.due = cyc + LAT; r.d = tabm ? er2 : m_read(c2.addr); q2.push_back(r);
    end
    if (a1 & c1.wr) m_write(c1);
    if (a2 & c2.wr) m_write(c2);
    if (!rr) begin
      if (coll) turn2 = ~turn2;
      else if (turn2 & a2 & c2.wr) turn2 = 1'b0;
    end
    last_w1 = mw1;
    last_w2 = mw2;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    cmd_t i0, cur1, cur2;
    logic rr;
    i0 = idle_c();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    turn2 = 1'b0;

    tab.push_back(mk(wr_c(5, 32'hDEADBEEF, 4'hF), i0, 0, 0, 0, 0, 0));
    tab.push_back(mk(i0, rd_c(5), 0, 0, 0, 0, 32'hDEADBEEF));
    tab.push_back(mk(wr_c(7, 32'h11223344, 4'hF), i0, 0, 0, 0, 0, 0));
    tab.push_back(mk(i0, wr_c(7, 32'hAABBCCDD, 4'b0101), 0, 0, 0, 0, 0));
    tab.push_back(mk(rd_c(7), i0, 0, 0, 0, 32'h11BB33DD, 0));
    tab.push_back(mk(wr_c(3, 32'h1, 4'hF), wr_c(3, 32'h2, 4'hF), 0, 0, 1, 0, 0));
    tab.push_back(mk(i0, wr_c(3, 32'h2, 4'hF), 0, 0, 0, 0, 0));
    tab.push_back(mk(rd_c(3), i0, 0, 0, 0, 32'h2, 0));
    tab.push_back(mk(wr_c(3, 32'h1, 4'hF), wr_c(3, 32'h2, 4'hF), 0, 0, 1, 0, 0));
    tab.push_back(mk(wr_c(3, 32'h11, 4'hF), wr_c(3, 32'h2, 4'hF), 0, 1, 0, 0, 0));
    tab.push_back(mk(wr_c(3, 32'h11, 4'hF), i0, 0, 0, 0, 0, 0));
    tab.push_back(mk(i0, rd_c(3), 0, 0, 0, 0, 32'h11));
    tab.push_back(mk(wr_c(9, 32'hCAFE, 4'hF), rd_c(9), 0, 0, 0, 0, 32'h0));
    tab.push_back(mk(i0, rd_c(9), 0, 0, 0, 0, 32'hCAFE));
    tab.push_back(mk(i0, rd_c(5), 0, 0, 0, 0, 32'hDEADBEEF));
    for (int i = 0; i < 3; i++) tab.push_back(mk(wr_c(10, 32'h55AA55AA, 4'hF), i0, 1, 1, 1, 0, 0));
    tab.push_back(mk(wr_c(10, 32'h55AA55AA, 4'hF), rd_c(10), 0, 0, 0, 0, 32'h0));
    tab.push_back(mk(i0, rd_c(10), 0, 0, 0, 0, 32'h55AA55AA));
    for (int i = 0; i < 16; i++) tab.push_back(mk(rd_c(i), rd_c(15 - i), 0, 0, 0, expw(i), expw(15 - i)));
    tab.push_back(mk(wr_c(400, 32'h12345678, 4'hF), i0, 0, 0, 0, 0, 0));
    tab.push_back(mk(rd_c(400), rd_c(400), 0, 0, 0, 32'h0, 32'h0));
    tab.push_back(mk(wr_c(20, 32'h1, 4'hF), wr_c(20, 32'h2, 4'hF), 0, 0, 1, 0, 0));
    tab.push_back(mk(wr_c(20, 32'h1, 4'hF), wr_c(20, 32'h2, 4'hF), 1, 1, 1, 0, 0));
    tab.push_back(mk(wr_c(20, 32'h1, 4'hF), wr_c(20, 32'h2, 4'hF), 0, 1, 0, 0, 0));
    tab.push_back(mk(wr_c(20, 32'h1, 4'hF), i0, 0, 0, 0, 0, 0));
    tab.push_back(mk(i0, rd_c(20), 0, 0, 0, 0, 32'h1));
    for (int i = 0; i < 3; i++) tab.push_back(mk(i0, i0, 0, 0, 0, 0, 0));

    reset = 1'b1;
    drive(i0, i0, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset s1_readdata", s1_readdata, 32'h0);
    chk("reset s2_readdata", s2_readdata, 32'h0);
    chk("reset s1_readdatavalid", 32'(s1_readdatavalid), 32'd0);
    chk("reset s2_readdatavalid", 32'(s2_readdatavalid), 32'd0);
    chk("reset s1_waitrequest", 32'(s1_waitrequest), 32'd0);
    chk("reset s2_waitrequest", 32'(s2_waitrequest), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tab.size(); i++)
      run_cycle(tab[i].c1, tab[i].c2, tab[i].rr, 1'b1, tab[i].ew1, tab[i].ew2, tab[i].er1, tab[i].er2);

    cur1 = i0; cur2 = i0; last_w1 = 1'b0; last_w2 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!last_w1) cur1 = rand_c();
      if (!last_w2) cur2 = rand_c();
      rr = ($urandom_range(0, 15) == 0);
      run_cycle(cur1, cur2, rr, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    for (int i = 0; i < 4; i++) run_cycle(rd_c(i), rd_c(298 + i), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) run_cycle(i0, i0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    drive(rd_c(5), rd_c(7), 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midread s1_readdatavalid", 32'(s1_readdatavalid), 32'd0);
    chk("midread s2_readdatavalid", 32'(s2_readdatavalid), 32'd0);
    chk("midread s1_readdata", s1_readdata, 32'h0);
    chk("midread s2_readdata", s2_readdata, 32'h0);
    q1.delete();
    q2.delete();
    turn2 = 1'b0;
    drive(i0, i0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) run_cycle(i0, i0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    run_cycle(rd_c(5), i0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0);
    for (int i = 0; i < 3; i++) run_cycle(i0, i0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
